// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-port RAM: round-robin tie-break,
// bounded locked bursts and tagged read-data return. Optional ARB_FIXED_PRIO_EN makes A always win ties.
module ram_port_arbiter #(
   parameter int ADDR_W    = 6,
   parameter int DATA_W    = 8,
   parameter int RD_LAT    = 1,
   parameter int BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic              a_lock,
   input  logic              a_write_enable,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_read,
   input  logic              b_req,
   input  logic              b_lock,
   input  logic              b_write_enable,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_read,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_write_enable,
   input  logic [DATA_W-1:0] ram_read
);

   // Handshake: a beat transfers on the rising edge where req && gnt; gnt is
   // combinational and the requester keeps its beat stable until granted.
   typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} state_t;

   localparam logic [3:0] BMAX = 4'(BURST_MAX);

   state_t            state, state_nxt;
   logic              last_b, last_b_nxt;
   logic [3:0]        beat_cnt, beat_cnt_nxt;
   logic              win_a, win_b;
   logic              a_cont, b_cont, a_spent, b_spent;
   logic              rd_push;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_data;
   logic [RD_LAT-1:0] tag_v, tag_b;

   assign a_cont  = (state == OWN_A) && a_req && a_lock && (beat_cnt < BMAX);
   assign b_cont  = (state == OWN_B) && b_req && b_lock && (beat_cnt < BMAX);
   assign a_spent = (state == OWN_A) && (beat_cnt >= BMAX);
   assign b_spent = (state == OWN_B) && (beat_cnt >= BMAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last_b   <= 1'b1;
         beat_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         last_b   <= last_b_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = IDLE;
      beat_cnt_nxt = 4'd0;
      last_b_nxt   = last_b;
      if (win_a) begin
         last_b_nxt = 1'b0;
         if (a_lock) begin
            state_nxt    = OWN_A;
            beat_cnt_nxt = ((state == OWN_A) && (beat_cnt < BMAX)) ? beat_cnt + 4'd1 : 4'd1;
         end
      end else if (win_b) begin
         last_b_nxt = 1'b1;
         if (b_lock) begin
            state_nxt    = OWN_B;
            beat_cnt_nxt = ((state == OWN_B) && (beat_cnt < BMAX)) ? beat_cnt + 4'd1 : 4'd1;
         end
      end
   end

   // A spent owner yields to a waiting peer before the tie-break is consulted.
   always_comb begin
      win_a = 1'b0;
      win_b = 1'b0;
      if (rst_n) begin
         if (a_cont) begin
            win_a = 1'b1;
         end else if (b_cont) begin
            win_b = 1'b1;
         end else if (a_req && b_req) begin
            if (a_spent) begin
               win_b = 1'b1;
            end else if (b_spent) begin
               win_a = 1'b1;
            end else begin
`ifdef ARB_FIXED_PRIO_EN
               win_a = 1'b1;
`else
               win_a = last_b;
               win_b = !last_b;
`endif
            end
         end else begin
            win_a = a_req;
            win_b = b_req;
         end
      end
   end

   always_comb begin
      ram_addr         = hold_addr;
      ram_data         = hold_data;
      ram_write_enable = 1'b0;
      if (win_a) begin
         ram_addr         = a_addr;
         ram_data         = a_data;
         ram_write_enable = a_write_enable;
      end else if (win_b) begin
         ram_addr         = b_addr;
         ram_data         = b_data;
         ram_write_enable = b_write_enable;
      end
   end

   assign a_gnt   = win_a;
   assign b_gnt   = win_b;
   assign rd_push = (win_a && !a_write_enable) || (win_b && !b_write_enable);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_addr <= '0;
         hold_data <= '0;
      end else if (win_a || win_b) begin
         hold_addr <= ram_addr;
         hold_data <= ram_data;
      end
   end

   // Tag stage i holds reads accepted i+1 edges ago; the last stage lines up with ram_read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v    <= '0;
         tag_b    <= '0;
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         a_read   <= '0;
         b_read   <= '0;
      end else begin
         tag_v[0] <= rd_push;
         tag_b[0] <= win_b;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_b[i] <= tag_b[i-1];
         end
         a_rvalid <= tag_v[RD_LAT-1] && !tag_b[RD_LAT-1];
         b_rvalid <= tag_v[RD_LAT-1] && tag_b[RD_LAT-1];
         if (tag_v[RD_LAT-1] && !tag_b[RD_LAT-1]) a_read <= ram_read;
         if (tag_v[RD_LAT-1] && tag_b[RD_LAT-1])  b_read <= ram_read;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM stand-in, vector table, reset-in-flight
// sequence and random traffic scored against a rule-level model.
module tb_ram_port_arbiter;
   localparam int ADDR_W    = 6;
   localparam int DATA_W    = 8;
   localparam int RD_LAT    = 1;
   localparam int BURST_MAX = 4;
`ifdef ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   typedef struct {
      logic              a_req, a_lock, a_we;
      logic [ADDR_W-1:0] a_addr;
      logic [DATA_W-1:0] a_data;
      logic              b_req, b_lock, b_we;
      logic [ADDR_W-1:0] b_addr;
      logic [DATA_W-1:0] b_data;
      logic              exp_a, exp_b;
   } vec_t;

   logic              clk, rst_n;
   logic              a_req, a_lock, a_write_enable, a_gnt, a_rvalid;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data, a_read;
   logic              b_req, b_lock, b_write_enable, b_gnt, b_rvalid;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data, b_read;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_data, ram_read;
   logic              ram_write_enable;

   ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .BURST_MAX(BURST_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_lock(a_lock), .a_write_enable(a_write_enable), .a_addr(a_addr),
      .a_data(a_data), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_read(a_read),
      .b_req(b_req), .b_lock(b_lock), .b_write_enable(b_write_enable), .b_addr(b_addr),
      .b_data(b_data), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_read(b_read),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_write_enable(ram_write_enable),
      .ram_read(ram_read)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single-port RAM stand-in with RD_LAT-cycle read pipeline
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      if (ram_write_enable) mem[ram_addr] <= ram_data;
      rd_pipe[0] <= mem[ram_addr];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign ram_read = rd_pipe[RD_LAT-1];

   // reference model: owner 0 none / 1 A / 2 B, run = beats of the current locked burst
   int                owner, run, cyc, last_w;
   bit                last_was_b, hold_ok;
   logic [ADDR_W-1:0] hold_addr_m;
   logic [DATA_W-1:0] hold_data_m;
   logic [DATA_W-1:0] ref_mem [2**ADDR_W];
   logic [24:0]       exp_q[$];
   int                total, bad;
   vec_t              tab [24];
   vec_t              rv;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic int pick(input vec_t v);
      if (owner == 1 && v.a_req && v.a_lock && run < BURST_MAX) return 1;
      if (owner == 2 && v.b_req && v.b_lock && run < BURST_MAX) return 2;
      if (v.a_req && v.b_req) begin
         if (owner == 1 && run >= BURST_MAX) return 2;
         if (owner == 2 && run >= BURST_MAX) return 1;
         if (FIXED) return 1;
         return last_was_b ? 1 : 2;
      end
      if (v.a_req) return 1;
      if (v.b_req) return 2;
      return 0;
   endfunction

   function automatic vec_t mk(input logic ar, al, aw, input int aa, ad,
                               input logic br, bl, bw, input int ba, bd, input logic ea, eb);
      vec_t v;
      v.a_req = ar; v.a_lock = al; v.a_we = aw; v.a_addr = 6'(aa); v.a_data = 8'(ad);
      v.b_req = br; v.b_lock = bl; v.b_we = bw; v.b_addr = 6'(ba); v.b_data = 8'(bd);
      v.exp_a = ea; v.exp_b = eb;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      a_req = v.a_req; a_lock = v.a_lock; a_write_enable = v.a_we; a_addr = v.a_addr; a_data = v.a_data;
      b_req = v.b_req; b_lock = v.b_lock; b_write_enable = v.b_we; b_addr = v.b_addr; b_data = v.b_data;
   endtask

   task automatic check_rvalid();
      logic ea, eb;
      logic [DATA_W-1:0] ed;
      logic [24:0] e;
      ea = 1'b0; eb = 1'b0; ed = '0;
      if (exp_q.size() > 0 && exp_q[0][24:9] == cyc[15:0]) begin
         e = exp_q.pop_front();
         eb = e[8];
         ea = !e[8];
         ed = e[7:0];
      end
      check("a_rvalid", a_rvalid, ea);
      check("b_rvalid", b_rvalid, eb);
      if (ea) check("a_read", a_read, ed);
      if (eb) check("b_read", b_read, ed);
   endtask

   // driver: one cycle of stimulus, comb checks, then model update on the edge
   task automatic step(input vec_t v, input bit tab_chk);
      int w;
      logic we, lk;
      logic [ADDR_W-1:0] ad;
      logic [DATA_W-1:0] dt;
      @(negedge clk);
      check_rvalid();
      drive(v);
      #1;
      w = pick(v);
      check("a_gnt", a_gnt, w == 1);
      check("b_gnt", b_gnt, w == 2);
      if (tab_chk) begin
         check("tab_a_gnt", a_gnt, v.exp_a);
         check("tab_b_gnt", b_gnt, v.exp_b);
      end
      we = (w == 1) ? v.a_we : v.b_we;
      lk = (w == 1) ? v.a_lock : v.b_lock;
      ad = (w == 1) ? v.a_addr : v.b_addr;
      dt = (w == 1) ? v.a_data : v.b_data;
      if (w != 0) begin
         check("ram_addr", ram_addr, ad);
         check("ram_data", ram_data, dt);
         check("ram_we", ram_write_enable, we);
      end else begin
         check("ram_we_idle", ram_write_enable, 1'b0);
         if (hold_ok) begin
            check("ram_addr_hold", ram_addr, hold_addr_m);
            check("ram_data_hold", ram_data, hold_data_m);
         end
      end
      @(posedge clk);
      cyc++;
      last_w = w;
      if (w != 0) begin
         if (we) ref_mem[ad] = dt;
         else exp_q.push_back({16'(cyc + RD_LAT), (w == 2), ref_mem[ad]});
         hold_ok = 1'b1; hold_addr_m = ad; hold_data_m = dt;
         if (lk) begin
            run = (owner == w && run < BURST_MAX) ? run + 1 : 1;
            owner = w;
         end else begin
            owner = 0; run = 0;
         end
         last_was_b = (w == 2);
      end else begin
         owner = 0; run = 0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(mk(0,0,0,0,0, 0,0,0,0,0, 0,0), 1'b0);
   endtask

   // asserts reset with a write pending, so ram_write_enable gating is visible
   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n = 1'b0;
      drive(mk(1,0,1,5,8'h5a, 0,0,0,0,0, 0,0));
      for (int i = 0; i < n; i++) begin
         #1;
         check("rst_a_rvalid", a_rvalid, 1'b0);
         check("rst_b_rvalid", b_rvalid, 1'b0);
         check("rst_a_read", a_read, '0);
         check("rst_b_read", b_read, '0);
         check("rst_ram_we", ram_write_enable, 1'b0);
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      owner = 0; run = 0; last_was_b = 1'b1; hold_ok = 1'b0; last_w = 0;
      exp_q.delete();
      drive(mk(0,0,0,0,0, 0,0,0,0,0, 0,0));
      rst_n = 1'b1;
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0;
      for (int i = 0; i < 2**ADDR_W; i++) begin mem[i] = '0; ref_mem[i] = '0; end
      rst_n = 1'b0;
      drive(mk(0,0,0,0,0, 0,0,0,0,0, 0,0));

      //           A: req lk we addr data   B: req lk we addr data   exp A, B
      tab[0]  = mk(1,0,1,0,8'h01,  0,0,0,0,0,       1,0);
      tab[1]  = mk(1,0,0,0,0,      0,0,0,0,0,       1,0);
      tab[2]  = mk(1,0,0,0,0,      1,0,0,1,0,       FIXED,!FIXED);
      tab[3]  = mk(1,0,0,0,0,      1,0,0,1,0,       1,0);
      tab[4]  = mk(1,0,0,0,0,      1,0,0,1,0,       FIXED,!FIXED);
      tab[5]  = mk(0,0,0,0,0,      1,0,1,2,8'h44,   0,1);
      tab[6]  = mk(1,0,0,2,0,      0,0,0,0,0,       1,0);
      tab[7]  = mk(0,0,0,0,0,      0,0,0,0,0,       0,0);
      tab[8]  = mk(0,0,0,0,0,      1,0,0,3,0,       0,1);
      tab[9]  = mk(1,1,0,4,0,      1,0,0,5,0,       1,0);
      tab[10] = mk(1,1,0,4,0,      1,0,0,5,0,       1,0);
      tab[11] = mk(1,1,0,4,0,      1,0,0,5,0,       1,0);
      tab[12] = mk(1,1,0,4,0,      1,0,0,5,0,       1,0);
      tab[13] = mk(1,1,0,4,0,      1,0,0,5,0,       0,1);
      tab[14] = mk(1,1,0,4,0,      1,0,0,5,0,       1,0);
      tab[15] = mk(0,0,0,0,0,      0,0,0,0,0,       0,0);
      tab[16] = mk(1,1,0,6,0,      0,0,0,0,0,       1,0);
      tab[17] = mk(1,1,0,6,0,      0,0,0,0,0,       1,0);
      tab[18] = mk(1,1,0,6,0,      0,0,0,0,0,       1,0);
      tab[19] = mk(1,1,0,6,0,      0,0,0,0,0,       1,0);
      tab[20] = mk(1,1,0,6,0,      0,0,0,0,0,       1,0);
      tab[21] = mk(1,1,0,6,0,      1,0,0,7,0,       1,0);
      tab[22] = mk(0,0,0,0,0,      1,0,0,7,0,       0,1);
      tab[23] = mk(0,0,0,0,0,      0,0,0,0,0,       0,0);

      do_reset(2);
      for (int i = 0; i < 24; i++) step(tab[i], 1'b1);
      idle(3);

      // read in flight when reset hits: its rvalid must never appear
      step(mk(1,0,0,2,0, 0,0,0,0,0, 1,0), 1'b1);
      do_reset(2);
      idle(3);
      step(mk(1,0,0,0,0, 1,0,0,1,0, 1,0), 1'b1);
      idle(2);

      rv = mk(0,0,0,0,0, 0,0,0,0,0, 0,0);
      last_w = 0;
      for (int i = 0; i < 400; i++) begin
         if (!(rv.a_req && last_w != 1)) begin
            rv.a_req  = ($urandom_range(0, 3) != 0);
            rv.a_lock = 1'($urandom_range(0, 1));
            rv.a_we   = ($urandom_range(0, 2) == 0);
            rv.a_addr = 6'($urandom_range(0, 7));
            rv.a_data = 8'($urandom);
         end
         if (!(rv.b_req && last_w != 2)) begin
            rv.b_req  = ($urandom_range(0, 3) != 0);
            rv.b_lock = 1'($urandom_range(0, 1));
            rv.b_we   = ($urandom_range(0, 2) == 0);
            rv.b_addr = 6'($urandom_range(0, 7));
            rv.b_data = 8'($urandom);
         end
         step(rv, 1'b0);
      end
      idle(RD_LAT + 3);
      check("exp_q_drained", exp_q.size(), 0);

`ifdef ARB_FIXED_PRIO_EN
      for (int i = 0; i < 6; i++) step(mk(1,0,0,i,0, 1,0,0,9,0, 1,0), 1'b1);
      step(mk(0,0,0,0,0, 1,0,0,9,0, 0,1), 1'b1);
      idle(RD_LAT + 2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
